// File: rtl/bcd_cascade_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_cascade_counter_if
//  Description : Control/data bundle of the cascadable BCD counter.
//                master = controller side, slave = counter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_cascade_counter_if #(
  parameter int DIGITS = 3
);
  logic                  enable;
  logic                  up;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic                  done;
  logic                  overflow;

  modport master (
    output enable, up, clear, load, load_value,
    input  count, done, overflow
  );

  modport slave (
    input  enable, up, clear, load, load_value,
    output count, done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/bcd_cascade_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_cascade_counter
//  Description : DIGITS-decade BCD up/down counter with synchronous clear,
//                wrap or saturate at the terminal value, combinational
//                terminal-count strobe (done) for chaining, and a sticky
//                overflow flag. Optional parallel load is built only when
//                the macro BCD_LOAD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_cascade_counter #(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  bcd_cascade_counter_if.slave bus
);

  localparam int c_WIDTH    = 4 * DIGITS;
  localparam bit c_SATURATE = (WRAP == 1'b0);

  logic [c_WIDTH-1:0] r_count;
  logic               r_overflow;
  logic [c_WIDTH-1:0] w_step;
  logic [DIGITS:0]    w_run9;   // bit i: decades 0..i-1 all hold 9
  logic [DIGITS:0]    w_run0;   // bit i: decades 0..i-1 all hold 0
  logic               w_term;
  logic               w_tick;

  assign w_run9[0] = 1'b1;
  assign w_run0[0] = 1'b1;

  // Per-decade ripple of the "all lower decades at 9/0" condition and the
  // stepped value of each decade. The terminal case falls out naturally:
  // every decade moves and rolls over.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_d;
      logic       w_move;
      assign w_d           = r_count[4*i +: 4];
      assign w_run9[i+1]   = w_run9[i] & (w_d == 4'd9);
      assign w_run0[i+1]   = w_run0[i] & (w_d == 4'd0);
      assign w_move        = bus.up ? w_run9[i] : w_run0[i];
      assign w_step[4*i +: 4] =
          !w_move ? w_d :
          bus.up  ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) :
                    ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
    end
  endgenerate

  assign w_term = bus.up ? w_run9[DIGITS] : w_run0[DIGITS];
  assign w_tick = bus.enable & w_term;

`ifdef BCD_LOAD_EN
  logic [c_WIDTH-1:0] w_load;

  // Out-of-range load nibbles are clamped so a decade never holds 10..15.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_load_clamp
      assign w_load[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ?
                                4'd9 : bus.load_value[4*i +: 4];
    end
  endgenerate
`else
  // Load path is not built; fold the idle ports into a sink signal.
  logic w_unused_load;
  assign w_unused_load = ^{bus.load, bus.load_value};
`endif

  // Count and sticky overflow: reset > clear > load > enable > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
`ifdef BCD_LOAD_EN
    end else if (bus.load) begin
      r_count    <= w_load;
`endif
    end else if (bus.enable) begin
      if (!(w_term && c_SATURATE)) begin
        r_count <= w_step;
      end
      if (w_term) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.done     = w_tick & ~reset;

endmodule
`default_nettype wire
